alu_seq_core: RTL and testbench

Parametrised, handshaked successor to the 8-bit combinational ALU. It executes one operation per transaction on WIDTH-bit operands and keeps a persistent SF/CF/ZF/OF flag register. It adds carry-chained ADC/SBB, corrected flag rules, and an iterative one-bit-per-cycle shifter. It sits between the register-file read stage and write-back, with a valid/ready handshake on both sides.

---
 rtl/alu_seq_core.sv | 221 ++++++++++++++++++++++
 tb/tb_alu_seq_core.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_core.sv
// Handshaked WIDTH-bit ALU with a persistent {SF,CF,ZF,OF} flag register and an
// iterative shifter that moves one bit per cycle before presenting its result.
module alu_seq_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);
  localparam int M  = WIDTH - 1;
  localparam int CW = 6;
  localparam logic [CW-1:0]    N_MAX   = CW'(WIDTH);
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

  localparam logic [4:0] OP_ADD   = 5'd1;
  localparam logic [4:0] OP_AND   = 5'd2;
  localparam logic [4:0] OP_SUB   = 5'd3;
  localparam logic [4:0] OP_OR    = 5'd4;
  localparam logic [4:0] OP_XOR   = 5'd5;
  localparam logic [4:0] OP_PASSB = 5'd6;
  localparam logic [4:0] OP_NOTA  = 5'd8;
  localparam logic [4:0] OP_SAR   = 5'd9;
  localparam logic [4:0] OP_SHR   = 5'd10;
  localparam logic [4:0] OP_SAL   = 5'd11;
  localparam logic [4:0] OP_SHL   = 5'd12;
  localparam logic [4:0] OP_ADC   = 5'd13;
  localparam logic [4:0] OP_SBB   = 5'd14;
  localparam logic [4:0] OP_INC   = 5'd15;
  localparam logic [4:0] OP_DEC   = 5'd16;
  localparam logic [4:0] OP_CMP   = 5'd20;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_HOLD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             shl_q, shl_d;
  logic             sar_q, sar_d;
  logic             amsb_q, amsb_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;

  logic             cf_q;
  logic             accept;
  logic             is_shift;
  logic [CW-1:0]    n_amt;

  assign cf_q      = flags_q[2];
  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_HOLD);
  assign result    = result_q;
  assign flags     = flags_q;

  assign is_shift = (op == OP_SAR) || (op == OP_SHR) || (op == OP_SAL) || (op == OP_SHL);
  assign n_amt    = (b >= WIDTH_V) ? N_MAX : CW'(b);

  // Non-shift datapath; flag_v is the value SF/ZF are taken from (differs from R for CMP)
  logic [WIDTH:0]   arith;
  logic [WIDTH-1:0] alu_r;
  logic [WIDTH-1:0] flag_v;
  logic             alu_cf;
  logic             alu_of;
  logic             alu_wr;

  always_comb begin
    arith  = '0;
    alu_r  = '0;
    flag_v = '0;
    alu_cf = 1'b0;
    alu_of = 1'b0;
    alu_wr = 1'b0;
    case (op)
      OP_ADD, OP_ADC: begin
        arith  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (op == OP_ADC) & cf_q};
        alu_r  = arith[M:0];
        flag_v = alu_r;
        alu_cf = arith[WIDTH];
        alu_of = (a[M] == b[M]) && (alu_r[M] != a[M]);
        alu_wr = 1'b1;
      end
      OP_SUB, OP_SBB, OP_CMP: begin
        arith  = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, (op == OP_SBB) & cf_q};
        flag_v = arith[M:0];
        alu_r  = (op == OP_CMP) ? a : flag_v;
        alu_cf = arith[WIDTH];
        alu_of = (a[M] != b[M]) && (flag_v[M] != a[M]);
        alu_wr = 1'b1;
      end
      OP_INC: begin
        arith  = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
        alu_r  = arith[M:0];
        flag_v = alu_r;
        alu_cf = arith[WIDTH];
        alu_of = (a == {1'b0, {M{1'b1}}});
        alu_wr = 1'b1;
      end
      OP_DEC: begin
        arith  = {1'b0, a} - {{WIDTH{1'b0}}, 1'b1};
        alu_r  = arith[M:0];
        flag_v = alu_r;
        alu_cf = arith[WIDTH];
        alu_of = (a == {1'b1, {M{1'b0}}});
        alu_wr = 1'b1;
      end
      OP_AND: begin
        alu_r  = a & b;
        flag_v = alu_r;
        alu_wr = 1'b1;
      end
      OP_OR: begin
        alu_r  = a | b;
        flag_v = alu_r;
        alu_wr = 1'b1;
      end
      OP_XOR: begin
        alu_r  = a ^ b;
        flag_v = alu_r;
        alu_wr = 1'b1;
      end
      OP_PASSB: alu_r = b;
      OP_NOTA:  alu_r = ~a;
      default:  alu_r = '0;
    endcase
  end

  // One shift step on the working register; out_bit is the bit leaving it
  logic [WIDTH-1:0] step;
  logic             out_bit;

  always_comb begin
    step    = '0;
    out_bit = 1'b0;
    if (shl_q) begin
      step    = {work_q[M-1:0], 1'b0};
      out_bit = work_q[M];
    end else begin
      step    = {sar_q & work_q[M], work_q[M:1]};
      out_bit = work_q[0];
    end
  end

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    shl_d    = shl_q;
    sar_d    = sar_q;
    amsb_d   = amsb_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      S_IDLE, S_HOLD: begin
        if ((state_q == S_HOLD) && out_ready && !in_valid) begin
          state_d = S_IDLE;
        end
        if (accept) begin
          if (is_shift && (n_amt != '0)) begin
            state_d = S_SHIFT;
            work_d  = a;
            cnt_d   = n_amt;
            shl_d   = (op == OP_SAL) || (op == OP_SHL);
            sar_d   = (op == OP_SAR);
            amsb_d  = a[M];
          end else if (is_shift) begin
            state_d  = S_HOLD;
            result_d = a;
            flags_d  = {a[M], 1'b0, (a == '0), 1'b0};
          end else begin
            state_d  = S_HOLD;
            result_d = alu_r;
            if (alu_wr) begin
              flags_d = {flag_v[M], alu_cf, (flag_v == '0), alu_of};
            end
          end
        end
      end
      S_SHIFT: begin
        work_d = step;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == {{(CW-1){1'b0}}, 1'b1}) begin
          state_d  = S_HOLD;
          result_d = step;
          flags_d  = {step[M], out_bit, (step == '0), (step[M] != amsb_q)};
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      work_q   <= '0;
      cnt_q    <= '0;
      shl_q    <= 1'b0;
      sar_q    <= 1'b0;
      amsb_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      shl_q    <= shl_d;
      sar_q    <= sar_d;
      amsb_q   <= amsb_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed bench for alu_seq_core: a vector table at WIDTH=8 plus hand sequences
// for back-to-back issue, backpressure, reset mid-shift and a WIDTH=16 instance.
module tb_alu_seq_core;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid, in_ready, out_valid, out_ready;
  logic [4:0] op;
  logic [7:0] a, b, result;
  logic [3:0] flags;

  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [4:0]  op16;
  logic [15:0] a16, b16, result16;
  logic [3:0]  flags16;

  alu_seq_core #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags)
  );

  alu_seq_core #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16), .op(op16),
    .a(a16), .b(b16), .out_valid(out_valid16), .out_ready(out_ready16), .result(result16),
    .flags(flags16)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic [3:0] f;
    int         lat;
  } vec_t;

  vec_t vecs[22];

  // Issue one op on the 8-bit DUT and wait for its result, then drain it.
  task automatic do_op8(input logic [4:0] o, input logic [7:0] va, input logic [7:0] vb,
                        output logic [7:0] r, output logic [3:0] f, output int lat,
                        output logic rdy_in, output logic rdy_hold);
    @(negedge clk);
    op = o; a = va; b = vb; in_valid = 1'b1; out_ready = 1'b1;
    rdy_in = in_ready;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    rdy_hold = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = c;
        rdy_hold = in_ready;
        break;
      end
    end
    r = result;
    f = flags;
    @(posedge clk);
    #1;
  endtask

  task automatic do_op16(input logic [4:0] o, input logic [15:0] va, input logic [15:0] vb,
                         output logic [15:0] r, output logic [3:0] f, output int lat);
    @(negedge clk);
    op16 = o; a16 = va; b16 = vb; in_valid16 = 1'b1; out_ready16 = 1'b1;
    @(posedge clk);
    #1 in_valid16 = 1'b0;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (out_valid16) begin
        lat = c;
        break;
      end
    end
    r = result16;
    f = flags16;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  r8;
    logic [15:0] r16;
    logic [3:0]  f;
    int          lat;
    int          seen;
    logic        rdy_in, rdy_hold;

    // flags are {SF,CF,ZF,OF}; order matters because flags persist between ops
    vecs[0]  = '{5'd1,  8'h7F, 8'h01, 8'h80, 4'b1001, 1};
    vecs[1]  = '{5'd1,  8'hFF, 8'h01, 8'h00, 4'b0110, 1};
    vecs[2]  = '{5'd13, 8'h00, 8'h00, 8'h01, 4'b0000, 1};
    vecs[3]  = '{5'd9,  8'h90, 8'd3,  8'hF2, 4'b1000, 4};
    vecs[4]  = '{5'd9,  8'h90, 8'd200, 8'hFF, 4'b1100, 9};
    vecs[5]  = '{5'd20, 8'h10, 8'h20, 8'h10, 4'b1100, 1};
    vecs[6]  = '{5'd6,  8'h55, 8'h00, 8'h00, 4'b1100, 1};
    vecs[7]  = '{5'd3,  8'h80, 8'h01, 8'h7F, 4'b0001, 1};
    vecs[8]  = '{5'd3,  8'h00, 8'h01, 8'hFF, 4'b1100, 1};
    vecs[9]  = '{5'd14, 8'h05, 8'h02, 8'h02, 4'b0000, 1};
    vecs[10] = '{5'd15, 8'h7F, 8'h00, 8'h80, 4'b1001, 1};
    vecs[11] = '{5'd16, 8'h80, 8'h00, 8'h7F, 4'b0001, 1};
    vecs[12] = '{5'd16, 8'h00, 8'h00, 8'hFF, 4'b1100, 1};
    vecs[13] = '{5'd2,  8'hF0, 8'h0F, 8'h00, 4'b0010, 1};
    vecs[14] = '{5'd8,  8'h0F, 8'h00, 8'hF0, 4'b0010, 1};
    vecs[15] = '{5'd5,  8'hFF, 8'h0F, 8'hF0, 4'b1000, 1};
    vecs[16] = '{5'd10, 8'h81, 8'd1,  8'h40, 4'b0101, 2};
    vecs[17] = '{5'd12, 8'h81, 8'd0,  8'h81, 4'b1000, 1};
    vecs[18] = '{5'd11, 8'hC0, 8'd2,  8'h00, 4'b0111, 3};
    vecs[19] = '{5'd4,  8'h00, 8'h00, 8'h00, 4'b0010, 1};
    vecs[20] = '{5'd7,  8'h12, 8'h34, 8'h00, 4'b0010, 1};
    vecs[21] = '{5'd12, 8'h01, 8'd8,  8'h00, 4'b0110, 9};

    in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    in_valid16 = 1'b0; out_ready16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;

    #1;
    check("rst_result", 32'(result), 32'h0);
    check("rst_flags", 32'(flags), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_out_valid16", 32'(out_valid16), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      do_op8(vecs[i].op, vecs[i].a, vecs[i].b, r8, f, lat, rdy_in, rdy_hold);
      $display("[TB] vec %0d op=%0d a=%02h b=%02h -> r=%02h f=%04b lat=%0d",
               i, vecs[i].op, vecs[i].a, vecs[i].b, r8, f, lat);
      check($sformatf("vec%0d_in_ready", i), 32'(rdy_in), 32'h1);
      check($sformatf("vec%0d_hold_in_ready", i), 32'(rdy_hold), 32'h1);
      check($sformatf("vec%0d_result", i), 32'(r8), 32'(vecs[i].r));
      check($sformatf("vec%0d_flags", i), 32'(f), 32'(vecs[i].f));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
    end

    // Back-to-back: ADC accepted from HOLD sees the CF of the ADD being drained
    @(negedge clk);
    op = 5'd1; a = 8'hFF; b = 8'h01; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 op = 5'd13; a = 8'h00; b = 8'h00;
    @(negedge clk);
    $display("[TB] b2b ADD r=%02h f=%04b v=%0b", result, flags, out_valid);
    check("b2b_add_valid", 32'(out_valid), 32'h1);
    check("b2b_add_result", 32'(result), 32'h00);
    check("b2b_add_flags", 32'(flags), 32'b0110);
    check("b2b_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    $display("[TB] b2b ADC r=%02h f=%04b v=%0b", result, flags, out_valid);
    check("b2b_adc_valid", 32'(out_valid), 32'h1);
    check("b2b_adc_result", 32'(result), 32'h01);
    check("b2b_adc_flags", 32'(flags), 32'b0000);
    @(posedge clk);
    #1;

    // Backpressure: XOR result held while a pending ADD waits
    @(negedge clk);
    op = 5'd5; a = 8'hAA; b = 8'h55; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 op = 5'd1; a = 8'h01; b = 8'h01;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      $display("[TB] stall %0d r=%02h f=%04b v=%0b rdy=%0b", i, result, flags, out_valid, in_ready);
      check("stall_valid", 32'(out_valid), 32'h1);
      check("stall_result", 32'(result), 32'hFF);
      check("stall_flags", 32'(flags), 32'b1000);
      check("stall_in_ready", 32'(in_ready), 32'h0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1 check("release_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    $display("[TB] after stall ADD r=%02h f=%04b v=%0b", result, flags, out_valid);
    check("release_add_valid", 32'(out_valid), 32'h1);
    check("release_add_result", 32'(result), 32'h02);
    check("release_add_flags", 32'(flags), 32'b0000);
    @(posedge clk);
    #1;

    // Reset during cycle 3 of SHL by 7, with non-zero result/flags beforehand
    do_op8(5'd1, 8'h7F, 8'h01, r8, f, lat, rdy_in, rdy_hold);
    check("pre_rst_flags", 32'(f), 32'b1001);
    @(negedge clk);
    op = 5'd12; a = 8'h01; b = 8'd7; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    $display("[TB] mid-shift reset r=%02h f=%04b v=%0b rdy=%0b", result, flags, out_valid, in_ready);
    check("midrst_result", 32'(result), 32'h0);
    check("midrst_flags", 32'(flags), 32'h0);
    check("midrst_out_valid", 32'(out_valid), 32'h0);
    check("midrst_in_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("no_valid_after_rst", 32'(seen), 32'h0);
    do_op8(5'd1, 8'h03, 8'h04, r8, f, lat, rdy_in, rdy_hold);
    $display("[TB] post-reset ADD r=%02h f=%04b lat=%0d", r8, f, lat);
    check("post_rst_result", 32'(r8), 32'h07);
    check("post_rst_flags", 32'(f), 32'b0000);
    check("post_rst_latency", 32'(lat), 32'h1);

    // WIDTH=16 instance
    do_op16(5'd12, 16'h0001, 16'd15, r16, f, lat);
    $display("[TB] w16 SHL r=%04h f=%04b lat=%0d", r16, f, lat);
    check("w16_shl_result", 32'(r16), 32'h8000);
    check("w16_shl_flags", 32'(f), 32'b1001);
    check("w16_shl_latency", 32'(lat), 32'd16);
    do_op16(5'd9, 16'h8000, 16'd20, r16, f, lat);
    $display("[TB] w16 SAR r=%04h f=%04b lat=%0d", r16, f, lat);
    check("w16_sar_result", 32'(r16), 32'hFFFF);
    check("w16_sar_flags", 32'(f), 32'b1100);
    check("w16_sar_latency", 32'(lat), 32'd17);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
